// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter style up/down counter.
// Command encoding plus the wrap/saturate mode constants.
package pc_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_INC  = 3'd3,
    CMD_DEC  = 3'd4
  } cmd_e;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

endpackage

// File: rtl/inc_n.sv
// WIDTH-generic combinational +1 with carry-out.
module inc_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  assign {co, sum} = {1'b0, a} + (WIDTH+1)'(1);

endmodule

// File: rtl/pc_counter.sv
// Up/down counter over 0..LIMIT with load, clear, wrap or saturate at the ends.
// One prioritised command per clock edge; wrap is a one-cycle registered pulse.
module pc_counter
  import pc_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = {WIDTH{1'b1}},
  parameter bit               SAT   = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  cmd_e             cmd;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_co;
  logic [WIDTH-1:0] out_nxt;
  logic             wrap_nxt;

  inc_n #(.WIDTH(WIDTH)) u_inc (
    .a   (out),
    .sum (inc_sum),
    .co  (inc_co)
  );

  always_comb begin
    cmd = CMD_HOLD;
    if (clr)               cmd = CMD_CLR;
    else if (load)         cmd = CMD_LOAD;
    else if (inc && !dec)  cmd = CMD_INC;
    else if (dec && !inc)  cmd = CMD_DEC;
  end

  // Carry-out covers the full-range case; out == LIMIT covers reduced ranges.
  always_comb begin
    out_nxt  = out;
    wrap_nxt = 1'b0;
    unique case (cmd)
      CMD_CLR:  out_nxt = '0;
      CMD_LOAD: out_nxt = (in > LIMIT) ? LIMIT : in;
      CMD_INC: begin
        if (inc_co || (out == LIMIT)) begin
          if (SAT == MODE_WRAP) begin
            out_nxt  = '0;
            wrap_nxt = 1'b1;
          end
        end else begin
          out_nxt = inc_sum;
        end
      end
      CMD_DEC: begin
        if (out == '0) begin
          if (SAT == MODE_WRAP) begin
            out_nxt  = LIMIT;
            wrap_nxt = 1'b1;
          end
        end else begin
          out_nxt = out - ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      out  <= out_nxt;
      wrap <= wrap_nxt;
    end
  end

  assign at_max  = (out == LIMIT);
  assign at_zero = (out == '0);

endmodule

// File: tb/tb_pc_counter.sv
// Scoreboard bench for pc_counter: three instances (16-bit wrap, 0..9 wrap, 0..9 saturate)
// share one command stream; stimulus queues expected results, a monitor checks them.
module tb_pc_counter;

  logic        clk = 1'b0;
  logic        rst_n, clr, load, inc, dec;
  logic [15:0] in16;

  logic [15:0] out16;
  logic        w16, mx16, z16;
  logic [3:0]  out_w, out_s;
  logic        ww, mxw, zw, ws, mxs, zs;

  always #5 clk = ~clk;

  pc_counter u_d16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .in(in16), .inc(inc), .dec(dec),
    .out(out16), .wrap(w16), .at_max(mx16), .at_zero(z16)
  );

  pc_counter #(.WIDTH(4), .LIMIT(4'd9), .SAT(1'b0)) u_d9w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .in(in16[3:0]), .inc(inc), .dec(dec),
    .out(out_w), .wrap(ww), .at_max(mxw), .at_zero(zw)
  );

  pc_counter #(.WIDTH(4), .LIMIT(4'd9), .SAT(1'b1)) u_d9s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .in(in16[3:0]), .inc(inc), .dec(dec),
    .out(out_s), .wrap(ws), .at_max(mxs), .at_zero(zs)
  );

  typedef struct {
    int          due;
    int          sel;
    string       name;
    logic [15:0] out;
    logic        wrap;
    logic        mx;
    logic        z;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   wrap_cnt = 0;
  bit   cnt_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (cnt_en && w16) wrap_cnt++;

  // Monitor: pop every expectation whose sampling edge has passed.
  exp_t        e;
  logic [18:0] act, req;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      case (e.sel)
        0:       act = {out16, w16, mx16, z16};
        1:       act = {12'h000, out_w, ww, mxw, zw};
        default: act = {12'h000, out_s, ws, mxs, zs};
      endcase
      req = {e.out, e.wrap, e.mx, e.z};
      checks++;
      if (act !== req) begin
        failures++;
        $display("FAIL %s: got out=%h wrap=%b at_max=%b at_zero=%b, want out=%h wrap=%b at_max=%b at_zero=%b",
                 e.name, act[18:3], act[2], act[1], act[0], req[18:3], req[2], req[1], req[0]);
      end
    end
  end

  task automatic drive(input bit r, input bit c, input bit l, input bit i, input bit d,
                       input logic [15:0] v);
    @(negedge clk);
    rst_n = r; clr = c; load = l; inc = i; dec = d; in16 = v;
  endtask

  task automatic expect_q(input int sel, input string name, input logic [15:0] o,
                          input bit w, input bit mx, input bit z);
    exp_t x;
    x.due = cyc + 1; x.sel = sel; x.name = name;
    x.out = o; x.wrap = w; x.mx = mx; x.z = z;
    sbq.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; inc = 1'b0; dec = 1'b0; in16 = 16'h0;

    drive(0,0,0,0,0,0); expect_q(0, "rst16", 16'h0, 0, 0, 1);
                        expect_q(1, "rst9w", 16'h0, 0, 0, 1);

    // count up 5, reset mid-count, resume
    drive(1,0,0,1,0,0); expect_q(0, "up1", 16'd1, 0, 0, 0);
    drive(1,0,0,1,0,0); expect_q(0, "up2", 16'd2, 0, 0, 0);
    drive(1,0,0,1,0,0); expect_q(0, "up3", 16'd3, 0, 0, 0);
    drive(1,0,0,1,0,0); expect_q(0, "up4", 16'd4, 0, 0, 0);
    drive(1,0,0,1,0,0); expect_q(0, "up5", 16'd5, 0, 0, 0);
    drive(0,0,0,1,0,0); expect_q(0, "rst_mid", 16'd0, 0, 0, 1);
    drive(1,0,0,1,0,0); expect_q(0, "resume", 16'd1, 0, 0, 0);

    // 16-bit wrap both directions
    drive(1,0,1,0,0,16'hFFFE); expect_q(0, "ld_fffe", 16'hFFFE, 0, 0, 0);
    drive(1,0,0,1,0,0);        expect_q(0, "inc_ffff", 16'hFFFF, 0, 1, 0);
    drive(1,0,0,1,0,0);        expect_q(0, "inc_wrap", 16'h0000, 1, 0, 1);
    drive(1,0,0,0,0,0);        expect_q(0, "wrap_1cyc", 16'h0000, 0, 0, 1);
    drive(1,0,0,0,1,0);        expect_q(0, "dec_wrap", 16'hFFFF, 1, 1, 0);
    drive(1,0,0,0,0,0);        expect_q(0, "dec_wrap_end", 16'hFFFF, 0, 1, 0);

    // LIMIT=9: clamp on load, wrap / saturate at ends
    drive(1,0,1,0,0,16'd12); expect_q(1, "ld12_clamp_w", 16'd9, 0, 1, 0);
                             expect_q(2, "ld12_clamp_s", 16'd9, 0, 1, 0);
    drive(1,0,0,1,0,0);      expect_q(1, "w_inc_wrap", 16'd0, 1, 0, 1);
                             expect_q(2, "s_inc_hold", 16'd9, 0, 1, 0);
    drive(1,0,0,0,1,0);      expect_q(1, "w_dec_wrap", 16'd9, 1, 1, 0);
                             expect_q(2, "s_dec8", 16'd8, 0, 0, 0);
    drive(1,0,1,0,0,16'd9);  expect_q(2, "s_ld9", 16'd9, 0, 1, 0);
    drive(1,0,0,1,0,0);      expect_q(2, "s_sat1", 16'd9, 0, 1, 0);
    drive(1,0,0,1,0,0);      expect_q(2, "s_sat2", 16'd9, 0, 1, 0);
    drive(1,0,0,1,0,0);      expect_q(2, "s_sat3", 16'd9, 0, 1, 0);
    drive(1,1,0,0,0,0);      expect_q(2, "s_clr", 16'd0, 0, 0, 1);
    drive(1,0,0,0,1,0);      expect_q(2, "s_dec_zero", 16'd0, 0, 0, 1);
    drive(1,0,1,0,0,16'd9);  expect_q(1, "w_ld9", 16'd9, 0, 1, 0);
    drive(1,1,0,1,0,0);      expect_q(1, "w_clr_inc", 16'd0, 0, 0, 1);

    // priority
    drive(1,0,1,0,0,16'd5);    expect_q(0, "ld5", 16'd5, 0, 0, 0);
    drive(1,1,1,1,0,16'd7);    expect_q(0, "clr_ld_inc", 16'd0, 0, 0, 1);
    drive(1,0,1,0,0,16'd5);    expect_q(0, "ld5b", 16'd5, 0, 0, 0);
    drive(1,0,1,1,0,16'd7);    expect_q(0, "ld_inc", 16'd7, 0, 0, 0);
    drive(1,0,0,1,1,0);        expect_q(0, "inc_dec", 16'd7, 0, 0, 0);
    drive(1,0,1,0,0,16'hFFFF); expect_q(0, "ld_ffff", 16'hFFFF, 0, 1, 0);
    drive(1,0,1,1,0,16'h0000); expect_q(0, "ld_inc_at_max", 16'h0000, 0, 0, 1);

    // free run: 70000 increments from 0
    drive(1,1,0,0,0,0); expect_q(0, "fr_clr", 16'd0, 0, 0, 1);
    drive(1,0,0,1,0,0);
    wrap_cnt = 0;
    cnt_en   = 1'b1;
    repeat (70000) @(posedge clk);
    drive(1,0,0,0,0,0); expect_q(0, "free_run", 16'd4464, 0, 0, 0);
    drive(1,0,0,0,0,0);
    cnt_en = 1'b0;
    repeat (3) @(negedge clk);

    checks++;
    if (wrap_cnt != 1) begin
      failures++;
      $display("FAIL free_run_wraps: got %0d pulses, want 1", wrap_cnt);
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_counter.md
PC_COUNTER -- requirements
Module: pc_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter LIMIT, default 2**WIDTH-1: terminal count value; the legal count range is 0..LIMIT; requires 1 <= LIMIT <= 2**WIDTH-1.
REQ-003 SHALL have parameter SAT, default 0: 0 = wrap at the range ends, 1 = saturate at the range ends.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear of the count to 0.
REQ-007 SHALL have port load, input, 1 bit: load the count from in.
REQ-008 SHALL have port in, input, WIDTH bits: load value.
REQ-009 SHALL have port inc, input, 1 bit: count up by 1.
REQ-010 SHALL have port dec, input, 1 bit: count down by 1.
REQ-011 SHALL have port out, output, WIDTH bits: current count, registered.
REQ-012 SHALL have port wrap, output, 1 bit: registered pulse, high for the cycle following any edge on which the count wrapped.
REQ-013 SHALL have port at_max, output, 1 bit: combinational, equal to (out == LIMIT).
REQ-014 SHALL have port at_zero, output, 1 bit: combinational, equal to (out == 0).

Function
REQ-015 SHALL evaluate one command per rising clk edge, in strict priority order: rst_n low > clr > load > (inc XOR dec) > hold.
REQ-016 SHALL update out at the edge on which the command is sampled (latency one cycle); inputs are not registered beforehand.
REQ-017 SHALL, on load, set out = in when in <= LIMIT; otherwise out = LIMIT.
REQ-018 SHALL, on inc with out < LIMIT, set out = out+1.
REQ-019 SHALL, on inc with out == LIMIT: set out = 0 and wrap = 1 when SAT=0; hold out with wrap = 0 when SAT=1.
REQ-020 SHALL, on dec with out > 0, set out = out-1.
REQ-021 SHALL, on dec with out == 0: set out = LIMIT and wrap = 1 when SAT=0; hold out with wrap = 0 when SAT=1.
REQ-022 SHALL hold out when inc and dec are both high, or both low, with no load, clr or reset active.
REQ-023 SHALL drive wrap = 0 on every edge other than those defined in REQ-019 and REQ-021; a wrap pulse never lasts longer than one cycle unless consecutive wraps occur.
REQ-024 SHALL, with LIMIT = 2**WIDTH-1, produce natural modulo-2**WIDTH arithmetic (0xFFFF+1 -> 0 at WIDTH=16).
REQ-025 SHALL, when clr or load coincides with inc or dec, ignore inc and dec and drive wrap = 0.

Reset
REQ-026 SHALL, on a rising clk edge with rst_n = 0, set out = 0 and wrap = 0, overriding every other input; after reset, at_zero = 1 and at_max = 0.
REQ-027 SHALL resume normal priority operation on the first edge with rst_n = 1, including when reset was asserted during counting.

Structure
REQ-028 SHALL place the command encoding (CMD_HOLD, CMD_CLR, CMD_LOAD, CMD_INC, CMD_DEC) and the mode constants (MODE_WRAP = 0, MODE_SAT = 1) in the shared package pc_pkg.
REQ-029 SHALL implement +1 through one parametrised combinational sub-module, inc_n (WIDTH-generic incrementer with carry-out); the decrement path is implemented inline.

Verification
REQ-030 SHALL cover reset: defaults; count up 5 edges, then rst_n = 0 for 1 edge -> out = 0, wrap = 0, at_zero = 1.
REQ-031 SHALL cover wrap at 16 bits: defaults; load 16'hFFFE, inc for 2 edges -> out = FFFF (at_max = 1), then out = 0000 with wrap = 1 for exactly one cycle; dec at 0 -> out = FFFF with wrap = 1.
REQ-032 SHALL cover modulo and clamp: WIDTH=4, LIMIT=9; load 12 -> out = 9; inc -> out = 0 with wrap = 1; dec -> out = 9 with wrap = 1.
REQ-033 SHALL cover saturation: WIDTH=4, LIMIT=9, SAT=1; at out = 9, inc for 3 edges -> out stays 9, wrap = 0; at out = 0, dec -> out stays 0.
REQ-034 SHALL cover priority: with out = 5, clr+load+inc -> out = 0; load(in=7)+inc -> out = 7; inc+dec together -> out = 7 held, wrap = 0.
REQ-035 SHALL cover a free run: defaults; inc held for 70000 edges from 0 -> out = 70000 mod 65536 = 4464, with exactly one wrap pulse observed.
